menu_ctrl: RTL

- Parametrised game-setup menu controller. Holds NUM_FIELDS independently bounded settings (board size, level, ...), plus a cursor that selects one field.
- Button presses are edge-detected, and held buttons auto-repeat. A start click launches the game; a game_over pulse returns control to the menu.
- Sits between the input decoders (keyboard/mouse) and the game core and renderer.

---
 rtl/menu_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/menu_ctrl.sv
// menu_ctrl: game-setup menu controller.
// Holds NUM_FIELDS bounded settings and a cursor selecting one of them.
// Navigation buttons act once on the press edge, then auto-repeat while
// held: the first repeat comes REPEAT_DELAY cycles after the press, and
// later repeats every REPEAT_PERIOD cycles. A start press launches the game.
// A game_over pulse returns control to the menu.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   i_btn_up       increment selected field (level, synchronous)
//   i_btn_down     decrement selected field
//   i_btn_right    move cursor to next field
//   i_btn_left     move cursor to previous field
//   i_start        launch game
//   i_game_over    single-cycle pulse from game core, back to menu
//   o_field_values packed settings, field i at [i*FIELD_W +: FIELD_W]
//   o_sel_field    cursor index
//   o_is_game_on   high while a game is running
//   o_changed      one-cycle pulse when any field or the cursor changes
module menu_ctrl #(
    parameter int                            NUM_FIELDS    = 2,
    parameter int                            FIELD_W       = 3,
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MIN     = {3'd1, 3'd2},
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX     = {3'd3, 3'd4},
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_INIT    = {3'd1, 3'd2},
    parameter bit                            WRAP          = 1'b0,
    parameter int                            REPEAT_DELAY  = 20000000,
    parameter int                            REPEAT_PERIOD = 5000000,
    localparam int                           SEL_W         = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_btn_up,
    input  logic                          i_btn_down,
    input  logic                          i_btn_right,
    input  logic                          i_btn_left,
    input  logic                          i_start,
    input  logic                          i_game_over,
    output logic [NUM_FIELDS*FIELD_W-1:0] o_field_values,
    output logic [SEL_W-1:0]              o_sel_field,
    output logic                          o_is_game_on,
    output logic                          o_changed
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SEL_W1  = SEL_W + 1;
    localparam int VAL_W1  = FIELD_W + 1;

    localparam logic [CNT_W-1:0]  CNT_DELAY  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]  CNT_PERIOD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [SEL_W1-1:0] SEL_LAST   = SEL_W1'(NUM_FIELDS - 1);

    typedef enum logic [1:0] {
        S_MENU = 2'd0,
        S_HOLD = 2'd1,
        S_GAME = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        B_NONE  = 3'd0,
        B_DOWN  = 3'd1,
        B_UP    = 3'd2,
        B_RIGHT = 3'd3,
        B_LEFT  = 3'd4
    } btn_t;

    state_t                        r_state;
    btn_t                          r_btn;
    logic [CNT_W-1:0]              r_cnt;
    logic [NUM_FIELDS*FIELD_W-1:0] r_fields;
    logic [SEL_W-1:0]              r_sel;
    logic                          r_game_on;
    logic                          r_changed;

    state_t                        w_state_nxt;
    btn_t                          w_btn_nxt;
    btn_t                          w_active;
    logic [CNT_W-1:0]              w_cnt_nxt;
    logic                          w_do_act;
    logic [FIELD_W-1:0]            w_cur;
    logic [FIELD_W-1:0]            w_min;
    logic [FIELD_W-1:0]            w_max;
    logic [VAL_W1-1:0]             w_inc;
    logic [FIELD_W-1:0]            w_val_nxt;
    logic [SEL_W-1:0]              w_sel_nxt;
    logic [NUM_FIELDS*FIELD_W-1:0] w_fields_nxt;
    logic                          w_changed;

    // Selected field value and its bounds.
    assign w_cur = r_fields[int'(r_sel)*FIELD_W +: FIELD_W];
    assign w_min = FIELD_MIN[int'(r_sel)*FIELD_W +: FIELD_W];
    assign w_max = FIELD_MAX[int'(r_sel)*FIELD_W +: FIELD_W];
    // The increment is one bit wider so that MAX = 2^FIELD_W-1 cannot overflow.
    assign w_inc = {1'b0, w_cur} + {{FIELD_W{1'b0}}, 1'b1};

    // Highest-priority navigation button (start is handled in the FSM).
    always_comb begin
        w_active = B_NONE;
        if (i_btn_down) begin
            w_active = B_DOWN;
        end else if (i_btn_up) begin
            w_active = B_UP;
        end else if (i_btn_right) begin
            w_active = B_RIGHT;
        end else if (i_btn_left) begin
            w_active = B_LEFT;
        end else begin
            w_active = B_NONE;
        end
    end

    // FSM next state, repeat counter and action strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_btn_nxt   = r_btn;
        w_cnt_nxt   = r_cnt;
        w_do_act    = 1'b0;
        case (r_state)
            S_MENU: begin
                if (i_start) begin
                    w_state_nxt = S_GAME;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (w_active != B_NONE) begin
                    w_do_act    = 1'b1;
                    w_cnt_nxt   = CNT_DELAY;
                    w_btn_nxt   = w_active;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_MENU;
                end
            end
            S_HOLD: begin
                if (i_start) begin
                    w_state_nxt = S_GAME;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (w_active != r_btn) begin
                    // Released or overridden: the next press is a fresh edge.
                    w_state_nxt = S_MENU;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_do_act  = 1'b1;
                    w_cnt_nxt = CNT_PERIOD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GAME: begin
                w_cnt_nxt = {CNT_W{1'b0}};
                if (i_game_over) begin
                    w_state_nxt = S_MENU;
                end else begin
                    w_state_nxt = S_GAME;
                end
            end
            default: begin
                w_state_nxt = S_MENU;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Action datapath: new value for the selected field, new cursor.
    always_comb begin
        w_val_nxt = w_cur;
        w_sel_nxt = r_sel;
        if (w_do_act) begin
            case (w_active)
                B_UP: begin
                    if (w_inc > {1'b0, w_max}) begin
                        w_val_nxt = WRAP ? w_min : w_cur;
                    end else begin
                        w_val_nxt = w_inc[FIELD_W-1:0];
                    end
                end
                B_DOWN: begin
                    if ({1'b0, w_cur} <= {1'b0, w_min}) begin
                        w_val_nxt = WRAP ? w_max : w_cur;
                    end else begin
                        w_val_nxt = w_cur - FIELD_W'(1);
                    end
                end
                B_RIGHT: begin
                    if ({1'b0, r_sel} >= SEL_LAST) begin
                        w_sel_nxt = WRAP ? {SEL_W{1'b0}} : r_sel;
                    end else begin
                        w_sel_nxt = r_sel + SEL_W'(1);
                    end
                end
                B_LEFT: begin
                    if (r_sel == {SEL_W{1'b0}}) begin
                        w_sel_nxt = WRAP ? SEL_LAST[SEL_W-1:0] : r_sel;
                    end else begin
                        w_sel_nxt = r_sel - SEL_W'(1);
                    end
                end
                default: begin
                    w_val_nxt = w_cur;
                    w_sel_nxt = r_sel;
                end
            endcase
        end else begin
            w_val_nxt = w_cur;
            w_sel_nxt = r_sel;
        end
        w_fields_nxt = r_fields;
        w_fields_nxt[int'(r_sel)*FIELD_W +: FIELD_W] = w_val_nxt;
        w_changed = (w_val_nxt != w_cur) || (w_sel_nxt != r_sel);
    end

    // State, counter, settings and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_MENU;
            r_btn     <= B_NONE;
            r_cnt     <= {CNT_W{1'b0}};
            r_fields  <= FIELD_INIT;
            r_sel     <= {SEL_W{1'b0}};
            r_game_on <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_btn     <= w_btn_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fields  <= w_fields_nxt;
            r_sel     <= w_sel_nxt;
            r_game_on <= (w_state_nxt == S_GAME);
            r_changed <= w_changed;
        end
    end

    assign o_field_values = r_fields;
    assign o_sel_field    = r_sel;
    assign o_is_game_on   = r_game_on;
    assign o_changed      = r_changed;

endmodule
